tdm_demux4: RTL and testbench

Four-channel time-division demultiplexer, the receive-side counterpart of the 4:1 mux datapath in Experiment 3. A single serial sample stream carrying channels 0..3 in rotating slots is locked to a frame-sync marker and distributed back onto four parallel registered outputs. Completed frames are presented atomically with a one-cycle `frame_valid` strobe.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_slot_counter.sv | 30 +++
 rtl/tdm_demux4.sv | 108 ++++++++++
 tb/tb_tdm_demux4.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants for the tdm_demux4 receive path: FSM encodings, slot bounds
// and channel count.
package tdm_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    localparam logic [1:0] SLOT_FIRST   = 2'd0;
    localparam logic [1:0] SLOT_LAST    = 2'd3;
    localparam int         TDM_CHANNELS = 4;

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-4 slot counter: clear beats load-to-1, which beats increment.
// The terminal-count flag marks the last slot of a frame.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       load1_i,
    input  logic       en_i,
    output logic [1:0] cnt_o,
    output logic       tc_o
);

    logic [1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= SLOT_FIRST;
        end else if (load1_i) begin
            cnt_q <= 2'd1;
        end else if (en_i) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer locked to a frame-sync marker.
// Optional framing checks enabled by defining TDM_DEMUX4_SYNC_CHECK_EN.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    tdm_state_e       state_q;
    logic [WIDTH-1:0] shadow_q [TDM_CHANNELS];
    logic [WIDTH-1:0] out_q    [TDM_CHANNELS];
    logic             frame_valid_q;
    logic             sync_err_q;

    logic [1:0] slot_cnt;
    logic       slot_tc;
    logic       hunt_sync_d;
    logic       in_lock_d;
    logic       mid_sync_d;
    logic       miss_sync_d;
    logic       normal_d;
    logic       frame_done_d;

    always_comb begin
        hunt_sync_d = din_valid && (state_q == ST_HUNT) && frame_sync;
        in_lock_d   = din_valid && (state_q == ST_LOCKED);
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        mid_sync_d  = in_lock_d && frame_sync && (slot_cnt != SLOT_FIRST);
        miss_sync_d = in_lock_d && !frame_sync && (slot_cnt == SLOT_FIRST);
`else
        // Without checking, LOCKED free-runs on the slot counter alone.
        mid_sync_d  = 1'b0;
        miss_sync_d = 1'b0;
`endif
        normal_d     = in_lock_d && !mid_sync_d && !miss_sync_d;
        frame_done_d = normal_d && slot_tc;
    end

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (miss_sync_d),
        .load1_i (hunt_sync_d || mid_sync_d),
        .en_i    (normal_d),
        .cnt_o   (slot_cnt),
        .tc_o    (slot_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int i = 0; i < TDM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            frame_valid_q <= frame_done_d;
            sync_err_q    <= mid_sync_d || miss_sync_d;
            if (hunt_sync_d) begin
                state_q     <= ST_LOCKED;
                shadow_q[0] <= din;
            end
            // A resync restarts the frame; earlier shadows are simply overwritten.
            if (mid_sync_d) begin
                shadow_q[0] <= din;
            end
            if (miss_sync_d) begin
                state_q <= ST_HUNT;
            end
            if (normal_d) begin
                shadow_q[slot_cnt] <= din;
            end
            // The last sample bypasses its shadow so the frame lands on this edge.
            if (frame_done_d) begin
                out_q[0] <= shadow_q[0];
                out_q[1] <= shadow_q[1];
                out_q[2] <= shadow_q[2];
                out_q[3] <= din;
            end
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign frame_valid = frame_valid_q;
    assign slot        = slot_cnt;
    assign locked      = (state_q == ST_LOCKED);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed frames then randomized traffic,
// compared against a frame-level model of the demultiplexer.
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] out0, out1, out2, out3;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    logic [4*W-1:0] exp_q [$];

    bit           m_locked;
    int           m_pos;
    logic [W-1:0] m_sh  [4];
    logic [W-1:0] m_out [4];
    bit           m_fv;
    bit           m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_fv     = 1'b0;
        m_err    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = '0;
            m_out[i] = '0;
        end
    endfunction

    // Frame-level behaviour: collect four slots, publish the whole frame at once.
    function automatic void model_step(input bit v, input bit s, input logic [W-1:0] d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_sh[0]  = d;
                m_pos    = 1;
                m_locked = 1'b1;
            end
            return;
        end
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        if (s && m_pos != 0) begin
            m_err   = 1'b1;
            m_sh[0] = d;
            m_pos   = 1;
            return;
        end
        if (!s && m_pos == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
            m_pos    = 0;
            return;
        end
`endif
        m_sh[m_pos] = d;
        if (m_pos == 3) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
            m_fv = 1'b1;
            exp_q.push_back({m_out[3], m_out[2], m_out[1], m_out[0]});
        end
        m_pos = (m_pos + 1) % 4;
    endfunction

    task automatic cycle(input bit v, input bit s, input logic [W-1:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(v, s, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b1, 1'b1, W'(4'hF));
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, W'($urandom));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("locked", {31'd0, locked}, {31'd0, m_locked});
            check("slot", {30'd0, slot}, m_pos);
            check("sync_err", {31'd0, sync_err}, {31'd0, m_err});
            check("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
            check("outputs", 32'({out3, out2, out1, out0}),
                  32'({m_out[3], m_out[2], m_out[1], m_out[0]}));
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("frame_pending", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("frame_data", 32'({out3, out2, out1, out0}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit v, s;
        do_reset();
        checking = 1'b1;

        // Reset and hunt: unsynced samples are discarded.
        cycle(1, 0, 1); cycle(1, 0, 0); cycle(1, 0, 1);
        idle(1);

        // Basic frame.
        cycle(1, 1, 0); cycle(1, 0, 1); cycle(1, 0, 0); cycle(1, 0, 1);
        idle(2);

        // Gapped frame.
        cycle(1, 1, 0); idle(3); cycle(1, 0, 1); idle(3);
        cycle(1, 0, 0); idle(3); cycle(1, 0, 1);
        idle(2);

        // Mid-frame resync.
        cycle(1, 1, 0); cycle(1, 0, 0);
        cycle(1, 1, 1); cycle(1, 0, 1); cycle(1, 0, 1); cycle(1, 0, 1);
        idle(2);

        // Reset mid-frame.
        cycle(1, 0, 5); cycle(1, 0, 6); cycle(1, 0, 7);
        do_reset();
        idle(2);

`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        // Loss of lock: good frame then slot-0 sample without sync.
        cycle(1, 1, 3); cycle(1, 0, 4); cycle(1, 0, 5); cycle(1, 0, 6);
        cycle(1, 0, 9);
        idle(2);
`endif

        // Randomized traffic with sparse resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 3) != 0);
                if (m_locked && m_pos == 0) s = ($urandom_range(0, 7) != 0);
                else                        s = ($urandom_range(0, 9) == 0);
                cycle(v, s, W'($urandom));
            end
        end
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
